// File: rtl/atomic_ctrl.sv
// LL/SC and plain load/store sequencer between the datapath data port and the
// cache port, driving the link register. Full LL/SC only with ATOMIC_CTRL_LLSC_EN.
module atomic_ctrl (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dp_ren,
  input  logic        dp_wen,
  input  logic        dp_ll,
  input  logic        dp_sc,
  input  logic [31:0] dp_addr,
  input  logic [31:0] dp_store,
  output logic [31:0] dp_load,
  output logic        dp_hit,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_store,
  input  logic [31:0] mem_load,
  input  logic        mem_wait,
  input  logic        snoop_inv,
  input  logic [31:0] snoop_addr,
  output logic        lm_update,
  output logic        lm_invalid,
  output logic [31:0] lm_addr_bus,
  output logic [31:0] lm_addr_cpu,
  input  logic        lm_write_valid
);
  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE, RD, WR, LL_RD, LL_LINK, SC_WR, SC_CLR, DONE
  } state_t;

  state_t state, state_n;
  word_t  result, result_n;
  word_t  addr_q, addr_n;
  word_t  store_q, store_n;
  logic   req;

  assign req       = dp_ren | dp_wen | dp_ll | dp_sc;
  assign dp_load   = result;
  assign mem_addr  = addr_q;
  assign mem_store = store_q;

`ifndef ATOMIC_CTRL_LLSC_EN
  // Without LL/SC the link-valid flag has no consumer.
  logic llsc_unused;
  assign llsc_unused = lm_write_valid;
`endif

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      result  <= '0;
      addr_q  <= '0;
      store_q <= '0;
    end else begin
      state   <= state_n;
      result  <= result_n;
      addr_q  <= addr_n;
      store_q <= store_n;
    end
  end

  always_comb begin
    state_n     = state;
    result_n    = result;
    addr_n      = addr_q;
    store_n     = store_q;
    dp_hit      = 1'b0;
    mem_ren     = 1'b0;
    mem_wen     = 1'b0;
    lm_update   = 1'b0;
    // Snoops are forwarded unless a link-port override below takes the bus.
    lm_invalid  = snoop_inv;
    lm_addr_bus = snoop_addr;
    lm_addr_cpu = addr_q;

    case (state)
      IDLE: begin
        lm_addr_cpu = dp_addr;
        if (req) begin
          addr_n  = dp_addr;
          store_n = dp_store;
        end
`ifdef ATOMIC_CTRL_LLSC_EN
        if (dp_ren)      state_n = RD;
        else if (dp_wen) state_n = WR;
        else if (dp_ll)  state_n = LL_RD;
        else if (dp_sc) begin
          // SC outcome is decided here and never revisited.
          if (lm_write_valid) begin
            state_n = SC_WR;
          end else begin
            result_n = '0;
            state_n  = DONE;
          end
        end
`else
        if (dp_ren | dp_ll) state_n = RD;
        else if (dp_wen)    state_n = WR;
        else if (dp_sc)     state_n = SC_WR;
`endif
      end

      RD, LL_RD: begin
        mem_ren = 1'b1;
        if (!mem_wait) begin
          result_n = mem_load;
          state_n  = (state == LL_RD) ? LL_LINK : DONE;
        end
      end

      WR: begin
        mem_wen = 1'b1;
        if (!mem_wait) state_n = DONE;
      end

      SC_WR: begin
        mem_wen = 1'b1;
        if (!mem_wait) begin
          result_n = 32'd1;
`ifdef ATOMIC_CTRL_LLSC_EN
          state_n  = SC_CLR;
`else
          state_n  = DONE;
`endif
        end
      end

`ifdef ATOMIC_CTRL_LLSC_EN
      LL_LINK: begin
        // A concurrent snoop owns the bus port; retry the link next cycle.
        if (!snoop_inv) begin
          lm_update   = 1'b1;
          lm_addr_bus = addr_q;
          state_n     = DONE;
        end
      end

      SC_CLR: begin
        lm_invalid = 1'b1;
        if (snoop_inv) begin
          // A snoop on our own address clears the link just as well.
          if (snoop_addr == addr_q) state_n = DONE;
        end else begin
          lm_addr_bus = addr_q;
          state_n     = DONE;
        end
      end
`endif

      DONE: begin
        dp_hit  = 1'b1;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_atomic_ctrl.sv
// Randomized self-checking bench for atomic_ctrl with a transaction-level
// reference model, a behavioural memory and a behavioural link register.
module tb_atomic_ctrl;
  logic        CLK = 0;
  logic        nRST;
  logic        dp_ren, dp_wen, dp_ll, dp_sc;
  logic [31:0] dp_addr, dp_store, dp_load;
  logic        dp_hit, mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_store, mem_load;
  logic        mem_wait, snoop_inv;
  logic [31:0] snoop_addr;
  logic        lm_update, lm_invalid;
  logic [31:0] lm_addr_bus, lm_addr_cpu;
  logic        lm_write_valid;

  int checks = 0;
  int errors = 0;

  atomic_ctrl dut (
    .CLK(CLK), .nRST(nRST),
    .dp_ren(dp_ren), .dp_wen(dp_wen), .dp_ll(dp_ll), .dp_sc(dp_sc),
    .dp_addr(dp_addr), .dp_store(dp_store), .dp_load(dp_load), .dp_hit(dp_hit),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_store(mem_store), .mem_load(mem_load), .mem_wait(mem_wait),
    .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
    .lm_update(lm_update), .lm_invalid(lm_invalid),
    .lm_addr_bus(lm_addr_bus), .lm_addr_cpu(lm_addr_cpu),
    .lm_write_valid(lm_write_valid)
  );

  always #5 CLK = ~CLK;

  // Environment: link register and memory.
  logic        link_v;
  logic [31:0] link_a;
  logic [31:0] env_mem [logic [31:0]];

  always @(posedge CLK) begin
    if (!nRST) link_v <= 1'b0;
    else if (lm_update) begin
      link_v <= 1'b1;
      link_a <= lm_addr_bus;
    end else if (lm_invalid && lm_addr_bus == link_a) link_v <= 1'b0;
  end
  assign lm_write_valid = link_v && (link_a == lm_addr_cpu);

  function automatic logic [31:0] env_rd(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  // Reference model state.
  logic        ref_link_v = 0;
  logic [31:0] ref_link_a = 0;
  logic [31:0] ref_last = 0;
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  // kind: 0 read, 1 write, 2 LL, 3 SC
  task automatic model_op(input int kind, input logic [31:0] a, d, input int w,
                          output int lat, output logic [31:0] ld,
                          output int nwen, output int nupd, output int ninv);
    nwen = 0; nupd = 0; ninv = 0; lat = 0; ld = ref_last;
`ifdef ATOMIC_CTRL_LLSC_EN
    case (kind)
      0: begin lat = 2 + w; ld = ref_rd(a); end
      1: begin lat = 2 + w; nwen = w + 1; ref_mem[a] = d; end
      2: begin
        lat = 3 + w; ld = ref_rd(a); nupd = 1;
        ref_link_v = 1; ref_link_a = a;
      end
      default: begin
        if (ref_link_v && ref_link_a == a) begin
          lat = 3 + w; nwen = w + 1; ninv = 1; ld = 32'd1;
          ref_mem[a] = d; ref_link_v = 0;
        end else begin
          lat = 1; ld = 32'd0;
        end
      end
    endcase
`else
    case (kind)
      0, 2: begin lat = 2 + w; ld = ref_rd(a); end
      1:    begin lat = 2 + w; nwen = w + 1; ref_mem[a] = d; end
      default: begin lat = 2 + w; nwen = w + 1; ref_mem[a] = d; ld = 32'd1; end
    endcase
`endif
    ref_last = ld;
  endtask

  task automatic idle_inputs();
    dp_ren = 0; dp_wen = 0; dp_ll = 0; dp_sc = 0;
    dp_addr = 0; dp_store = 0; mem_wait = 0; mem_load = 0;
    snoop_inv = 0; snoop_addr = 0;
  endtask

  // Drives one request until dp_hit, acting as memory; records what it saw.
  task automatic run_op(input int kind, input logic [31:0] a, d, input int nwait,
                        input int snp_cyc, input logic [31:0] snp_a,
                        output int hit_cyc, output logic [31:0] load,
                        output int n_wen, output int n_upd, output logic [31:0] upd_a,
                        output int upd_cyc, output int n_inv, output logic [31:0] inv_a);
    int cyc, left;
    @(negedge CLK);
    dp_ren = (kind == 0); dp_wen = (kind == 1); dp_ll = (kind == 2); dp_sc = (kind == 3);
    dp_addr = a; dp_store = d;
    cyc = 0; left = nwait; hit_cyc = -1; load = 0;
    n_wen = 0; n_upd = 0; upd_a = 0; upd_cyc = -1; n_inv = 0; inv_a = 0;
    while (hit_cyc < 0 && cyc < 64) begin
      snoop_inv  = (cyc == snp_cyc);
      snoop_addr = (cyc == snp_cyc) ? snp_a : 32'h0;
      #1;
      if (snoop_inv) begin
        checks++;
        if (lm_invalid !== 1'b1 || lm_addr_bus !== snp_a || lm_update !== 1'b0) begin
          errors++;
          $display("FAIL snoop_fwd cyc %0d: inv=%b addr=%h upd=%b, want inv=1 addr=%h upd=0",
                   cyc, lm_invalid, lm_addr_bus, lm_update, snp_a);
        end
      end else begin
        if (lm_update) begin
          n_upd++; upd_a = lm_addr_bus;
          if (upd_cyc < 0) upd_cyc = cyc;
        end
        if (lm_invalid) begin n_inv++; inv_a = lm_addr_bus; end
      end
      if (mem_wen) n_wen++;
      mem_load = $urandom;
      mem_wait = 0;
      if (mem_ren || mem_wen) begin
        if (left > 0) begin
          mem_wait = 1; left--;
        end else if (mem_ren) mem_load = env_rd(mem_addr);
        else env_mem[mem_addr] = mem_store;
      end
      if (dp_hit) begin
        hit_cyc = cyc; load = dp_load;
        dp_ren = 0; dp_wen = 0; dp_ll = 0; dp_sc = 0;
      end else begin
        @(negedge CLK);
        cyc++;
      end
    end
    snoop_inv = 0; snoop_addr = 0; mem_wait = 0;
    checks++;
    if (hit_cyc < 0) begin
      errors++;
      $display("FAIL hit_timeout kind %0d addr %h: no dp_hit in 64 cycles", kind, a);
      dp_ren = 0; dp_wen = 0; dp_ll = 0; dp_sc = 0;
    end
  endtask

  task automatic idle_snoop(input logic [31:0] a);
    @(negedge CLK);
    snoop_inv = 1; snoop_addr = a;
    #1;
    checks++;
    if (lm_invalid !== 1'b1 || lm_addr_bus !== a) begin
      errors++;
      $display("FAIL idle_snoop: inv=%b addr=%h, want inv=1 addr=%h", lm_invalid, lm_addr_bus, a);
    end
    if (ref_link_v && ref_link_a == a) ref_link_v = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    nRST = 0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({dp_hit, mem_ren, mem_wen, lm_update, lm_invalid} !== 5'b0 ||
        dp_load !== 0 || mem_addr !== 0 || mem_store !== 0 ||
        lm_addr_bus !== 0 || lm_addr_cpu !== 0) begin
      errors++;
      $display("FAIL reset_outputs: hit=%b ren=%b wen=%b upd=%b inv=%b load=%h maddr=%h, want all 0",
               dp_hit, mem_ren, mem_wen, lm_update, lm_invalid, dp_load, mem_addr);
    end
    nRST = 1;
    ref_last = 0; ref_link_v = 0;
  endtask

  task automatic test_read_wait();
    int hc, nw, nu, uc, ni, el, ew, eu, ei;
    logic [31:0] ld, ua, ia, eld;
    env_mem[32'h40] = 32'hDEADBEEF;
    ref_mem[32'h40] = 32'hDEADBEEF;
    run_op(0, 32'h40, 0, 2, -1, 0, hc, ld, nw, nu, ua, uc, ni, ia);
    model_op(0, 32'h40, 0, 2, el, eld, ew, eu, ei);
    checks++;
    if (hc !== 4 || hc !== el) begin
      errors++; $display("FAIL read_wait_lat: got %0d want 4", hc);
    end
    checks++;
    if (ld !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_wait_data: got %h want deadbeef", ld);
    end
  endtask

`ifdef ATOMIC_CTRL_LLSC_EN
  task automatic test_llsc_basic();
    int hc, nw, nu, uc, ni, el, ew, eu, ei;
    logic [31:0] ld, ua, ia, eld;
    run_op(2, 32'h100, 0, 0, -1, 0, hc, ld, nw, nu, ua, uc, ni, ia);
    model_op(2, 32'h100, 0, 0, el, eld, ew, eu, ei);
    checks++;
    if (hc !== 3 || nu !== 1 || ua !== 32'h100 || ld !== eld) begin
      errors++;
      $display("FAIL ll_basic: lat=%0d upd=%0d addr=%h load=%h, want 3 1 100 %h", hc, nu, ua, ld, eld);
    end
    run_op(3, 32'h100, 32'h55, 0, -1, 0, hc, ld, nw, nu, ua, uc, ni, ia);
    model_op(3, 32'h100, 32'h55, 0, el, eld, ew, eu, ei);
    checks++;
    if (hc !== 3 || nw !== 1 || env_rd(32'h100) !== 32'h55 || ni !== 1 || ia !== 32'h100 || ld !== 32'd1) begin
      errors++;
      $display("FAIL sc_basic: lat=%0d wen=%0d mem=%h inv=%0d ia=%h load=%h, want 3 1 55 1 100 1",
               hc, nw, env_rd(32'h100), ni, ia, ld);
    end
  endtask

  task automatic test_sc_fail_snoop();
    int hc, nw, nu, uc, ni, el, ew, eu, ei;
    logic [31:0] ld, ua, ia, eld;
    run_op(2, 32'h100, 0, 0, -1, 0, hc, ld, nw, nu, ua, uc, ni, ia);
    model_op(2, 32'h100, 0, 0, el, eld, ew, eu, ei);
    idle_snoop(32'h100);
    run_op(3, 32'h100, 32'h66, 0, -1, 0, hc, ld, nw, nu, ua, uc, ni, ia);
    model_op(3, 32'h100, 32'h66, 0, el, eld, ew, eu, ei);
    checks++;
    if (hc !== 1 || nw !== 0 || ld !== 32'd0) begin
      errors++;
      $display("FAIL sc_fail: lat=%0d wen=%0d load=%h, want 1 0 0", hc, nw, ld);
    end
  endtask

  task automatic test_snoop_link();
    int hc, nw, nu, uc, ni, el, ew, eu, ei;
    logic [31:0] ld, ua, ia, eld;
    run_op(2, 32'h100, 0, 0, 2, 32'h200, hc, ld, nw, nu, ua, uc, ni, ia);
    model_op(2, 32'h100, 0, 0, el, eld, ew, eu, ei);
    checks++;
    if (hc !== 4 || uc !== 3 || nu !== 1 || ua !== 32'h100) begin
      errors++;
      $display("FAIL snoop_link: lat=%0d upd_cyc=%0d upd=%0d addr=%h, want 4 3 1 100", hc, uc, nu, ua);
    end
  endtask
`else
  task automatic test_no_llsc();
    int hc, nw, nu, uc, ni, el, ew, eu, ei;
    logic [31:0] ld, ua, ia, eld;
    run_op(3, 32'h300, 32'h77, 0, -1, 0, hc, ld, nw, nu, ua, uc, ni, ia);
    model_op(3, 32'h300, 32'h77, 0, el, eld, ew, eu, ei);
    checks++;
    if (hc !== 2 || nw !== 1 || ld !== 32'd1 || nu !== 0 || env_rd(32'h300) !== 32'h77) begin
      errors++;
      $display("FAIL sc_plain: lat=%0d wen=%0d load=%h upd=%0d mem=%h, want 2 1 1 0 77",
               hc, nw, ld, nu, env_rd(32'h300));
    end
    run_op(2, 32'h300, 0, 1, -1, 0, hc, ld, nw, nu, ua, uc, ni, ia);
    model_op(2, 32'h300, 0, 1, el, eld, ew, eu, ei);
    checks++;
    if (hc !== 3 || ld !== 32'h77 || nu !== 0) begin
      errors++;
      $display("FAIL ll_plain: lat=%0d load=%h upd=%0d, want 3 77 0", hc, ld, nu);
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] addrs [4];
    int hc, nw, nu, uc, ni, el, ew, eu, ei, kind, w;
    logic [31:0] ld, ua, ia, eld, a, d;
    addrs[0] = 32'h100; addrs[1] = 32'h104; addrs[2] = 32'h200; addrs[3] = 32'h300;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 3) idle_snoop(addrs[$urandom_range(0, 3)]);
      kind = $urandom_range(0, 5);
      if (kind > 3) kind = kind - 2;
      a = addrs[$urandom_range(0, 3)];
      d = $urandom;
      w = $urandom_range(0, 3);
      run_op(kind, a, d, w, -1, 0, hc, ld, nw, nu, ua, uc, ni, ia);
      model_op(kind, a, d, w, el, eld, ew, eu, ei);
      checks++;
      if (hc !== el || ld !== eld) begin
        errors++;
        $display("FAIL rand_op %0d kind %0d addr %h: lat=%0d load=%h, want %0d %h", i, kind, a, hc, ld, el, eld);
      end
      checks++;
      if (nw !== ew || nu !== eu || ni !== ei || (eu == 1 && ua !== a) || (ei == 1 && ia !== a)) begin
        errors++;
        $display("FAIL rand_side %0d kind %0d: wen=%0d upd=%0d inv=%0d, want %0d %0d %0d", i, kind, nw, nu, ni, ew, eu, ei);
      end
      if (ew > 0) begin
        checks++;
        if (env_rd(a) !== ref_rd(a)) begin
          errors++;
          $display("FAIL rand_mem %0d addr %h: got %h want %h", i, a, env_rd(a), ref_rd(a));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    dp_ll = 1; dp_addr = 32'h180; dp_store = 32'h9; mem_wait = 1;
    @(negedge CLK);
    checks++;
    if (mem_ren !== 1'b1) begin
      errors++; $display("FAIL reset_mid_pre: mem_ren=%b want 1", mem_ren);
    end
    nRST = 0;
    @(negedge CLK);
    checks++;
    if ({dp_hit, mem_ren, mem_wen, lm_update, lm_invalid} !== 5'b0 ||
        dp_load !== 0 || mem_addr !== 0 || mem_store !== 0) begin
      errors++;
      $display("FAIL reset_mid: hit=%b ren=%b wen=%b upd=%b inv=%b load=%h, want all 0",
               dp_hit, mem_ren, mem_wen, lm_update, lm_invalid, dp_load);
    end
    nRST = 1; dp_ll = 0; mem_wait = 0;
    ref_last = 0; ref_link_v = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++;
      if (dp_hit !== 1'b0 || lm_update !== 1'b0) begin
        errors++; $display("FAIL reset_abandon cyc %0d: hit=%b upd=%b want 0 0", i, dp_hit, lm_update);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_wait();
`ifdef ATOMIC_CTRL_LLSC_EN
    test_llsc_basic();
    test_sc_fail_snoop();
    test_snoop_link();
`else
    test_no_llsc();
`endif
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
